// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch controller at the consumer end of the EX redirect path.
// Keeps the architectural PC and issues one req/ack read to imem at a time. Fetched words
// go into the IF/ID register, or into a 1-entry skid buffer while decode is stalled.
// A redirect from EX flushes wrong-path work and restarts fetch at ex_npc.
// Optional feature: define IF_FETCH_PERF_EN to add perf_redirect/perf_stall counters.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirect,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, DROP, ISSUE} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        id_valid_q;
  logic [31:0] id_inst_q, id_pc_q, id_pc4_q;
  logic        skid_vld_q;
  logic [31:0] skid_inst_q, skid_pc_q;

  logic [31:0] pc4_d;
  logic [31:0] npc_d;

  // Sequential PC (wraps mod 2^32) and the word-aligned redirect target.
  assign pc4_d = pc_q + 32'd4;
  assign npc_d = ex_npc & ~32'h3;

  // Fetch FSM. A redirect takes priority over stall and ack in every state. An outstanding
  // request is never abandoned: its ack is always consumed, and only then is the next one issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP;
      skid_pc_q   <= 32'd0;
    end else if (ex_is_jump) begin
      pc_q       <= npc_d;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP;
      skid_vld_q <= 1'b0;
      case (state_q)
        FETCH: begin
          // The bus request must complete before the new target can be issued.
          if (req_q && !imem_ack) begin
            state_q <= DROP;
          end else begin
            state_q <= ISSUE;
            req_q   <= 1'b0;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_q <= ISSUE;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= ISSUE;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            // First cycle out of reset: start the request at RESET_PC.
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end else if (imem_ack) begin
            req_q <= 1'b0;
            pc_q  <= pc4_d;
            if (stall && id_valid_q) begin
              skid_vld_q  <= 1'b1;
              skid_inst_q <= imem_rdata;
              skid_pc_q   <= pc_q;
              state_q     <= HOLD;
            end else begin
              id_valid_q <= 1'b1;
              id_inst_q  <= imem_rdata;
              id_pc_q    <= pc_q;
              id_pc4_q   <= pc4_d;
              state_q    <= ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall && skid_vld_q) begin
            id_valid_q <= 1'b1;
            id_inst_q  <= skid_inst_q;
            id_pc_q    <= skid_pc_q;
            id_pc4_q   <= skid_pc_q + 32'd4;
            skid_vld_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_redirect_q, perf_stall_q;

  // Event counters: redirect cycles, and cycles where decode actually holds a valid word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirect_q <= 32'd0;
      perf_stall_q    <= 32'd0;
    end else begin
      if (ex_is_jump)          perf_redirect_q <= perf_redirect_q + 32'd1;
      if (stall && id_valid_q) perf_stall_q    <= perf_stall_q + 32'd1;
    end
  end

  assign perf_redirect = perf_redirect_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a per-cycle vector table drives the main DUT through
// sequential fetch, stall/skid, redirect-while-pending, redirect+ack+stall, DROP retarget and
// stall-with-bubble. Hand-written sequences cover async reset and the RESET_PC wrap case.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam int          NV  = 34;

  logic        clk = 1'b0;
  logic        rst, stall, ex_is_jump, imem_ack;
  logic [31:0] ex_npc, imem_rdata;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_inst, id_pc, id_pc4;

  logic        rst1, ack1;
  logic [31:0] rdata1;
  logic        req1, vld1;
  logic [31:0] addr1, inst1, pc1, pc41;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_redirect, perf_stall, perf_redirect1, perf_stall1;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_is_jump(ex_is_jump), .ex_npc(ex_npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
`ifdef IF_FETCH_PERF_EN
    , .perf_redirect(perf_redirect), .perf_stall(perf_stall)
`endif
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst1), .stall(1'b0), .ex_is_jump(1'b0), .ex_npc(32'h0),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .id_valid(vld1), .id_inst(inst1), .id_pc(pc1), .id_pc4(pc41)
`ifdef IF_FETCH_PERF_EN
    , .perf_redirect(perf_redirect1), .perf_stall(perf_stall1)
`endif
  );

  typedef struct {
    logic        stall, jump;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc, inst;
  } vec_t;

  vec_t tv[NV];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(logic s, logic j, logic [31:0] npc, logic a, logic [31:0] rd,
                             logic rq, logic [31:0] ad, logic vl, logic [31:0] ipc,
                             logic [31:0] inst);
    vec_t r;
    r.stall = s; r.jump = j; r.npc = npc; r.ack = a; r.rdata = rd;
    r.req = rq; r.addr = ad; r.vld = vl; r.ipc = ipc; r.inst = inst;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int exp_redir, exp_stall;
    //        stall jump npc         ack rdata           req addr         vld id_pc        id_inst
    tv[0]  = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     0, 32'h0,   NOP);
    tv[1]  = v(0, 0, 32'h0,     0, 32'h0,         1, 32'h0,     0, 32'h0,   NOP);
    tv[2]  = v(0, 0, 32'h0,     1, K ^ 32'h0,     1, 32'h0,     0, 32'h0,   NOP);
    tv[3]  = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h0,   K ^ 32'h0);
    tv[4]  = v(0, 0, 32'h0,     0, 32'h0,         1, 32'h4,     1, 32'h0,   K ^ 32'h0);
    tv[5]  = v(0, 0, 32'h0,     1, K ^ 32'h4,     1, 32'h4,     1, 32'h0,   K ^ 32'h0);
    tv[6]  = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h4,   K ^ 32'h4);
    // stall held 5 cycles while id_valid; word 8 parks in the skid
    tv[7]  = v(1, 0, 32'h0,     0, 32'h0,         1, 32'h8,     1, 32'h4,   K ^ 32'h4);
    tv[8]  = v(1, 0, 32'h0,     1, K ^ 32'h8,     1, 32'h8,     1, 32'h4,   K ^ 32'h4);
    tv[9]  = v(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h4,   K ^ 32'h4);
    tv[10] = v(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h4,   K ^ 32'h4);
    tv[11] = v(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h4,   K ^ 32'h4);
    tv[12] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h4,   K ^ 32'h4);
    tv[13] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h8,   K ^ 32'h8);
    // redirect to 0x100 while request to 0xC pending; ack 3 cycles later
    tv[14] = v(0, 1, 32'h100,   0, 32'h0,         1, 32'hC,     1, 32'h8,   K ^ 32'h8);
    tv[15] = v(0, 0, 32'h0,     0, 32'h0,         1, 32'hC,     0, 32'h8,   NOP);
    tv[16] = v(0, 0, 32'h0,     0, 32'h0,         1, 32'hC,     0, 32'h8,   NOP);
    tv[17] = v(0, 0, 32'h0,     1, K ^ 32'hC,     1, 32'hC,     0, 32'h8,   NOP);
    tv[18] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     0, 32'h8,   NOP);
    tv[19] = v(0, 0, 32'h0,     0, 32'h0,         1, 32'h100,   0, 32'h8,   NOP);
    tv[20] = v(0, 0, 32'h0,     1, K ^ 32'h100,   1, 32'h100,   0, 32'h8,   NOP);
    tv[21] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h100, K ^ 32'h100);
    // redirect coincident with ack and stall; low target bits must be dropped
    tv[22] = v(1, 0, 32'h0,     0, 32'h0,         1, 32'h104,   1, 32'h100, K ^ 32'h100);
    tv[23] = v(1, 1, 32'h203,   1, K ^ 32'h104,   1, 32'h104,   1, 32'h100, K ^ 32'h100);
    tv[24] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     0, 32'h100, NOP);
    tv[25] = v(0, 0, 32'h0,     1, K ^ 32'h200,   1, 32'h200,   0, 32'h100, NOP);
    // stray ack with no request outstanding
    tv[26] = v(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 0, 32'h0,     1, 32'h200, K ^ 32'h200);
    // two redirects back to back: the second retargets the drop
    tv[27] = v(0, 1, 32'h300,   0, 32'h0,         1, 32'h204,   1, 32'h200, K ^ 32'h200);
    tv[28] = v(0, 1, 32'h400,   0, 32'h0,         1, 32'h204,   0, 32'h200, NOP);
    tv[29] = v(1, 0, 32'h0,     1, 32'h1234_5678, 1, 32'h204,   0, 32'h200, NOP);
    // stall while id_valid=0 does not block loading the bubble
    tv[30] = v(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,     0, 32'h200, NOP);
    tv[31] = v(1, 0, 32'h0,     1, K ^ 32'h400,   1, 32'h400,   0, 32'h200, NOP);
    tv[32] = v(0, 0, 32'h0,     0, 32'h0,         0, 32'h0,     1, 32'h400, K ^ 32'h400);
    tv[33] = v(0, 0, 32'h0,     0, 32'h0,         1, 32'h404,   1, 32'h400, K ^ 32'h400);

    rst = 1'b1; stall = 1'b0; ex_is_jump = 1'b0; ex_npc = '0; imem_ack = 1'b0; imem_rdata = '0;
    rst1 = 1'b1; ack1 = 1'b0; rdata1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_req",   {31'd0, imem_req}, 32'd0);
    chk("reset_addr",  imem_addr, 32'h0);
    chk("reset_valid", {31'd0, id_valid}, 32'd0);
    chk("reset_inst",  id_inst, NOP);
    chk("reset_pc",    id_pc, 32'h0);
    chk("reset_pc4",   id_pc4, 32'h0);
    rst = 1'b0;

    exp_redir = 0;
    exp_stall = 0;
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("c%0d_req", i),   {31'd0, imem_req}, {31'd0, tv[i].req});
      if (tv[i].req) chk($sformatf("c%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("c%0d_valid", i), {31'd0, id_valid}, {31'd0, tv[i].vld});
      chk($sformatf("c%0d_inst", i),  id_inst, tv[i].inst);
      chk($sformatf("c%0d_idpc", i),  id_pc, tv[i].ipc);
      if (tv[i].vld) chk($sformatf("c%0d_pc4", i), id_pc4, tv[i].ipc + 32'd4);
`ifdef IF_FETCH_PERF_EN
      chk($sformatf("c%0d_perf_redirect", i), perf_redirect, exp_redir);
      chk($sformatf("c%0d_perf_stall", i),    perf_stall, exp_stall);
      if (tv[i].jump) exp_redir++;
      if (tv[i].stall && tv[i].vld) exp_stall++;
`endif
      stall      = tv[i].stall;
      ex_is_jump = tv[i].jump;
      ex_npc     = tv[i].npc;
      imem_ack   = tv[i].ack;
      imem_rdata = tv[i].rdata;
      if (i < NV - 1) @(negedge clk);
    end

    // Async reset mid-FETCH: outputs clear without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    chk("async_req",   {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, id_valid}, 32'd0);
    chk("async_inst",  id_inst, NOP);
    chk("async_addr",  imem_addr, 32'h0);
`ifdef IF_FETCH_PERF_EN
    chk("async_perf_redirect", perf_redirect, 32'd0);
    chk("async_perf_stall",    perf_stall, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // RESET_PC at the top of the address space: the second request wraps to 0.
    rst1 = 1'b0;
    chk("wrap_req0", {31'd0, req1}, 32'd0);
    @(negedge clk);
    chk("wrap_req1",  {31'd0, req1}, 32'd1);
    chk("wrap_addr1", addr1, 32'hFFFF_FFFC);
    ack1 = 1'b1; rdata1 = K ^ 32'hFFFF_FFFC;
    @(negedge clk);
    ack1 = 1'b0;
    chk("wrap_valid", {31'd0, vld1}, 32'd1);
    chk("wrap_idpc",  pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4",   pc41, 32'h0);
    chk("wrap_inst",  inst1, K ^ 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_req2",  {31'd0, req1}, 32'd1);
    chk("wrap_addr2", addr1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
